// File: rtl/ctrl_pkg.sv
// Shared decode definitions: classes, opcode/funct codes, exception codes.
// Used by the predecoder and the decode issue queue.
package ctrl_pkg;

    typedef enum logic [3:0] {
        NONE,
        ALU,
        ALU_IMM,
        SHIFT,
        LOAD,
        STORE,
        BRANCH,
        JUMP,
        MULDIV,
        MFHILO,
        MTHILO,
        COP0,
        SYSCALL,
        ERET,
        RESERVED
    } instr_class_t;

    localparam logic [2:0] ctrlNoException        = 3'd0;
    localparam logic [2:0] ctrlUnknownInstruction = 3'd1;
    localparam logic [2:0] ctrlSyscall            = 3'd2;
    localparam logic [2:0] ctrlBreak              = 3'd3;
    localparam logic [2:0] ctrlERET               = 3'd4;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_COP0     = 6'h10;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_LHU      = 6'h25;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_BREAK   = 6'h0D;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    localparam logic [5:0] FN_MADD  = 6'h00;
    localparam logic [5:0] FN_MADDU = 6'h01;
    localparam logic [5:0] FN_MSUB  = 6'h04;
    localparam logic [5:0] FN_MSUBU = 6'h05;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    localparam logic [4:0]  RS_MF     = 5'h00;
    localparam logic [4:0]  RS_MT     = 5'h04;
    localparam logic [31:0] ERET_WORD = 32'h4200_0018;

    typedef struct packed {
        instr_class_t cls;
        logic [4:0]   src1;
        logic [4:0]   src2;
        logic         src1_req;
        logic         src2_req;
        logic [4:0]   dest;
        logic [2:0]   exc;
    } predecode_t;

    function automatic logic is_ctrl_xfer(input instr_class_t c);
        return (c == BRANCH) || (c == JUMP);
    endfunction

endpackage

// File: rtl/instr_predecode.sv
// Combinational MIPS predecoder: class, operand/dest registers, exception.
// Register 0 reads are still flagged as required; hazard logic masks r0.
module instr_predecode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output predecode_t  dec
);
    localparam logic [1:0] S_NO = 2'd0;
    localparam logic [1:0] S_RS = 2'd1;
    localparam logic [1:0] S_RT = 2'd2;
    localparam logic [1:0] D_NO = 2'd0;
    localparam logic [1:0] D_RD = 2'd1;
    localparam logic [1:0] D_RT = 2'd2;
    localparam logic [1:0] D_RA = 2'd3;

    logic [5:0]   op, fn;
    logic [4:0]   rs, rt, rd;
    instr_class_t cls;
    logic [2:0]   exc;
    logic [1:0]   s1, s2, ds;

    assign op = instr[31:26];
    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign rd = instr[15:11];
    assign fn = instr[5:0];

    always_comb begin
        cls = RESERVED;
        exc = ctrlNoException;
        s1  = S_NO;
        s2  = S_NO;
        ds  = D_NO;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA:
                        begin cls = SHIFT; s1 = S_RT; ds = D_RD; end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        cls = SHIFT; s1 = S_RT; s2 = S_RS; ds = D_RD;
                    end
                    FN_JR:   begin cls = JUMP; s1 = S_RS; end
                    FN_JALR: begin cls = JUMP; s1 = S_RS; ds = D_RD; end
                    FN_SYSCALL: begin cls = SYSCALL; exc = ctrlSyscall; end
                    FN_BREAK:   begin cls = SYSCALL; exc = ctrlBreak; end
                    FN_MFHI, FN_MFLO: begin cls = MFHILO; ds = D_RD; end
                    FN_MTHI, FN_MTLO: begin cls = MTHILO; s1 = S_RS; end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                        begin cls = MULDIV; s1 = S_RS; s2 = S_RT; end
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: begin
                        cls = ALU; s1 = S_RS; s2 = S_RT; ds = D_RD;
                    end
                    default: ;
                endcase
            end
            OP_SPECIAL2: begin
                case (fn)
                    FN_MADD, FN_MADDU, FN_MSUB, FN_MSUBU:
                        begin cls = MULDIV; s1 = S_RS; s2 = S_RT; end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BGEZ: begin cls = BRANCH; s1 = S_RS; end
                    RT_BLTZAL, RT_BGEZAL:
                        begin cls = BRANCH; s1 = S_RS; ds = D_RA; end
                    default: ;
                endcase
            end
            OP_J:   cls = JUMP;
            OP_JAL: begin cls = JUMP; ds = D_RA; end
            OP_BEQ, OP_BNE: begin cls = BRANCH; s1 = S_RS; s2 = S_RT; end
            OP_BLEZ, OP_BGTZ: begin cls = BRANCH; s1 = S_RS; end
            OP_LUI: begin cls = ALU_IMM; ds = D_RT; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI:
                begin cls = ALU_IMM; s1 = S_RS; ds = D_RT; end
            OP_COP0: begin
                if (instr == ERET_WORD) begin
                    cls = ERET; exc = ctrlERET;
                end else if (rs == RS_MF) begin
                    cls = COP0; ds = D_RT;
                end else if (rs == RS_MT) begin
                    cls = COP0; s1 = S_RT;
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
                begin cls = LOAD; s1 = S_RS; ds = D_RT; end
            OP_SB, OP_SH, OP_SW:
                begin cls = STORE; s1 = S_RS; s2 = S_RT; end
            default: ;
        endcase
        if (cls == RESERVED)
            exc = ctrlUnknownInstruction;
    end

    always_comb begin
        dec          = '0;
        dec.cls      = cls;
        dec.exc      = exc;
        dec.src1_req = (s1 != S_NO);
        dec.src2_req = (s2 != S_NO);
        dec.src1     = (s1 == S_RS) ? rs : (s1 == S_RT) ? rt : 5'd0;
        dec.src2     = (s2 == S_RS) ? rs : (s2 == S_RT) ? rt : 5'd0;
        case (ds)
            D_RD:    dec.dest = rd;
            D_RT:    dec.dest = rt;
            D_RA:    dec.dest = 5'd31;
            default: dec.dest = 5'd0;
        endcase
    end

endmodule

// File: rtl/decode_issue_queue.sv
// Multi-lane fetch-to-decode issue queue with predecode on enqueue.
// DECODE_ISSUE_BYPASS_EN: lane 0 may issue straight through an empty queue.
module decode_issue_queue
    import ctrl_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = 2,
    parameter int PC_W        = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [FETCH_WIDTH-1:0]    in_valid,
    input  logic [32*FETCH_WIDTH-1:0] in_instr,
    input  logic [PC_W-1:0]           in_pc,
    output logic                      in_ready,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [PC_W-1:0]           out_pc,
    output logic [3:0]                out_class,
    output logic [4:0]                out_src1,
    output logic [4:0]                out_src2,
    output logic                      out_src1_req,
    output logic                      out_src2_req,
    output logic [4:0]                out_dest,
    output logic [2:0]                out_exc,
    output logic                      out_in_delay_slot,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAXC = CW'(DEPTH - FETCH_WIDTH);

    logic [31:0]     instr_q [DEPTH];
    logic [PC_W-1:0] pc_q    [DEPTH];
    predecode_t      dec_q   [DEPTH];

    logic [PW-1:0] head, tail;
    logic          ds_flag;

    predecode_t       lane_dec [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] wr_en;
    logic [PW-1:0]    wr_idx [FETCH_WIDTH];
    logic [CW-1:0]    n_in, n_wr;
    logic             push_en, q_valid, byp, pop, q_pop, skip;
    predecode_t       hd_dec, vis;
    logic [31:0]      hd_instr;
    logic [PC_W-1:0]  hd_pc;

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_pd
        instr_predecode u_pd (
            .instr (in_instr[32*i +: 32]),
            .dec   (lane_dec[i])
        );
    end

    always_comb begin
        n_in = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            n_in = n_in + CW'(in_valid[i]);
    end

    assign in_ready = (count <= MAXC);
    assign push_en  = in_ready && (|in_valid) && !flush;

    // A branch/jump at the head waits until its delay slot is buffered.
    assign q_valid = (count != '0) &&
                     !(is_ctrl_xfer(dec_q[head].cls) && (count < CW'(2)));

`ifdef DECODE_ISSUE_BYPASS_EN
    assign byp = (count == '0) && in_valid[0] &&
                 !is_ctrl_xfer(lane_dec[0].cls);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        hd_dec   = dec_q[head];
        hd_instr = instr_q[head];
        hd_pc    = pc_q[head];
        if (byp) begin
            hd_dec   = lane_dec[0];
            hd_instr = in_instr[31:0];
            hd_pc    = in_pc;
        end
    end

    assign out_valid = q_valid || byp;
    assign pop       = out_valid && out_ready;
    assign skip      = byp && out_ready;
    assign q_pop     = pop && !byp;
    assign n_wr      = push_en ? (n_in - CW'(skip)) : '0;

    assign vis               = out_valid ? hd_dec : '0;
    assign out_instr         = out_valid ? hd_instr : '0;
    assign out_pc            = out_valid ? hd_pc : '0;
    assign out_class         = vis.cls;
    assign out_src1          = vis.src1;
    assign out_src2          = vis.src2;
    assign out_src1_req      = vis.src1_req;
    assign out_src2_req      = vis.src2_req;
    assign out_dest          = vis.dest;
    assign out_exc           = vis.exc;
    assign out_in_delay_slot = ds_flag;

    // A bypassed lane 0 is not stored, so later lanes slide down one slot.
    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            wr_en[i]  = push_en && in_valid[i] && !(skip && (i == 0));
            wr_idx[i] = tail + PW'(i) - PW'(skip);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (wr_en[i]) begin
                instr_q[wr_idx[i]] <= in_instr[32*i +: 32];
                pc_q[wr_idx[i]]    <= in_pc + PC_W'(4 * i);
                dec_q[wr_idx[i]]   <= lane_dec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ds_flag <= 1'b0;
        end else begin
            if (push_en)
                tail <= tail + PW'(n_wr);
            if (q_pop)
                head <= head + PW'(1);
            count <= count + n_wr - CW'(q_pop);
            if (pop)
                ds_flag <= is_ctrl_xfer(hd_dec.cls);
        end
    end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
- Parametrised successor to the single-instruction stage-D controller.
- Accepts up to FETCH_WIDTH fetched MIPS instructions per cycle into a circular buffer.
- Predecodes each instruction on enqueue: class, source/destination registers, read-required flags, exception code.
- Issues one predecoded instruction per cycle to the D/E pipeline, using a valid/ready handshake.
- Holds a branch or jump until its delay slot is also buffered; supports pipeline flush.

Parameters:
- DEPTH, 8: queue entries; power of 2, at least 2*FETCH_WIDTH.
- FETCH_WIDTH, 2: instruction lanes accepted per cycle (1..4).
- PC_W, 32: PC width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- in_valid  in  FETCH_WIDTH  per-lane valid; lanes contiguous from lane 0.
- in_instr  in  32*FETCH_WIDTH  instruction words, lane i at [32i+31:32i].
- in_pc  in  PC_W  PC of lane 0; lane i PC = in_pc + 4i.
- in_ready  out  1  queue accepts a full FETCH_WIDTH group this cycle.
- flush  in  1  discard all entries (redirect/exception).
- out_valid  out  1  head entry issuable.
- out_ready  in  1  downstream consumes head.
- out_instr  out  32  head instruction.
- out_pc  out  PC_W  head PC.
- out_class  out  4  instr_class_t of head.
- out_src1, out_src2  out  5  register read indices.
- out_src1_req, out_src2_req  out  1  the corresponding read is required.
- out_dest  out  5  destination register (0 = none).
- out_exc  out  3  ctrlNoException / ctrlUnknownInstruction / ctrlSyscall / ctrlBreak / ctrlERET.
- out_in_delay_slot  out  1  head is the delay slot of the previously issued branch/jump.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset==0 at posedge):
  - head=tail=count=0; delay-slot flag=0.
  - out_valid=0, in_ready=1.
  - All decoded outputs read 0 while out_valid=0.
- Push:
  - in_ready = (DEPTH - count) >= FETCH_WIDTH, computed on the registered count only; it ignores a same-cycle pop.
  - When in_ready and |in_valid, the popcount(in_valid) lanes are written at tail in lane order, and tail advances modulo DEPTH (wrap-around).
  - Predecode happens at write; decoded fields are stored per entry.
  - Non-contiguous in_valid is illegal; the bench asserts this never occurs.
- Pop:
  - out_valid = count>0 AND NOT (head class is BRANCH/JUMP AND count<2).
  - A branch or jump therefore never issues without its delay slot buffered.
  - A pop occurs when out_valid AND out_ready; head advances by 1 modulo DEPTH.
- Latency:
  - A push in cycle N is visible at the outputs in cycle N+1; there is no bypass unless the optional feature is enabled.
- Count update:
  - Next count = count + pushed - popped.
  - Simultaneous push and pop are allowed at any occupancy permitted by in_ready.
- Delay-slot tracking:
  - The flag is set when a BRANCH/JUMP pops and cleared on the next pop.
  - out_in_delay_slot equals the flag.
- Flush:
  - Next cycle: head=tail=count=0, flag=0.
  - Flush has priority; a same-cycle push and pop are both discarded and have no effect.
  - out_valid is still driven combinationally in the flush cycle, but the downstream stage ignores it.
- Predecode rules:
  - ALU: src1=rs, src2=rt, dest=rd.
  - Shift-immediate: src1=rt, no src2.
  - Shift-variable: src1=rt, src2=rs.
  - ALU_IMM and LOAD: src1=rs, dest=rt.
  - STORE: src1=rs, src2=rt.
  - beq/bne: src1=rs, src2=rt.
  - REGIMM/blez/bgtz: src1=rs only; bltzal/bgezal additionally dest=31.
  - jal: dest=31. jalr: dest=rd. jr: src1=rs.
  - mfc0: dest=rt. mtc0: src1=rt.
  - mult/div/madd/msub: src1=rs, src2=rt. mfhi/mflo: dest=rd. mthi/mtlo: src1=rs.
  - Unknown opcode/funct: class RESERVED, exc=ctrlUnknownInstruction.
- Register-0 handling:
  - out_srcN_req=1 whenever the instruction reads that operand, even if the index is 0; the hazard unit masks r0.

Optional Feature:
- Macro: DECODE_ISSUE_BYPASS_EN.
- With the macro defined:
  - When count==0 and in_valid[0] and lane 0 is not BRANCH/JUMP, lane 0 is presented at the outputs combinationally in the same cycle, with out_valid=1.
  - If out_ready, lane 0 is consumed and not written; the remaining lanes are written at tail.
  - Flush still has priority.
- Without the macro: the minimum push-to-issue latency is 1 cycle.

Decomposition:
- Package ctrl_pkg:
  - instr_class_t enum: NONE, ALU, ALU_IMM, SHIFT, LOAD, STORE, BRANCH, JUMP, MULDIV, MFHILO, MTHILO, COP0, SYSCALL, ERET, RESERVED.
  - The opcode/funct localparams, moved from the controller.
  - The exception code constants.
  - A predecode_t struct.
- Sub-module instr_predecode: purely combinational, 32-bit instruction in, predecode_t out; instantiated FETCH_WIDTH times at the write port.

Test Plan:
- Reset then push {addu $3,$1,$2; ori $5,$4,0x10} with out_ready=1:
  - cycle+1: out_class=ALU, src1=1, src2=2, dest=3.
  - cycle+2: ALU_IMM, src1=4, dest=5.
  - then count=0.
- Push beq $1,$2 alone in lane 0 (in_valid=01):
  - out_valid stays 0 with count=1.
  - Push the delay slot next: beq issues, then out_in_delay_slot=1 on the following entry.
- Fill DEPTH=8 with out_ready=0: in_ready drops at count=7. Then drain 3 and refill; check tail wrap and correct order of PCs.
- flush asserted while count=5 together with a push and out_ready: next cycle count=0, out_valid=0, and no pushed entry appears.
- Push word 0xFC000000 (unknown opcode): out_class=RESERVED, out_exc=ctrlUnknownInstruction.
- DECODE_ISSUE_BYPASS_EN build, empty queue, push addiu with out_ready=1: issued in the same cycle and count stays 0.
